// File: rtl/npu_sigmoid_router_fifo.sv
// Routes sigmoid-unit results into one of two independent FWFT FIFOs:
// the sigmoid feedback FIFO (dest=0) and the output FIFO (dest=1).
// A write to a full FIFO without a same-cycle read is dropped and latches
// the sticky overflow flag.
module npu_sigmoid_router_fifo #(
    parameter int unsigned SFIFO_DEPTH = 8,
    parameter int unsigned OFIFO_DEPTH = 16
) (
    input  logic                           CLK,
    input  logic                           npu_rst_n,
    input  logic                           npu_sched_sigmoid_valid,
    input  logic                           npu_sched_sigmoid_dest,
    input  logic [15:0]                    npu_sigmoid_dout,
    input  logic                           npu_sfifo_rd_en,
    input  logic                           npu_ofifo_rd_en,
    output logic [15:0]                    npu_sfifo_dout,
    output logic [15:0]                    npu_ofifo_dout,
    output logic                           npu_sfifo_empty,
    output logic                           npu_sfifo_full,
    output logic                           npu_ofifo_empty,
    output logic                           npu_ofifo_full,
    output logic [$clog2(OFIFO_DEPTH):0]   npu_ofifo_count,
    output logic                           npu_router_overflow
);

    localparam int unsigned SAW = $clog2(SFIFO_DEPTH);
    localparam int unsigned SCW = SAW + 1;
    localparam int unsigned OAW = $clog2(OFIFO_DEPTH);
    localparam int unsigned OCW = OAW + 1;

    logic           p1_valid_q, p1_dest_q;
    logic           overflow_q, overflow_d;

    logic [15:0]    s_mem [SFIFO_DEPTH];
    logic [SAW-1:0] s_wr_ptr_q, s_rd_ptr_q;
    logic [SCW-1:0] s_cnt_q, s_cnt_d;
    logic           s_wr_req, s_wr_acc, s_rd_acc;

    logic [15:0]    o_mem [OFIFO_DEPTH];
    logic [OAW-1:0] o_wr_ptr_q, o_rd_ptr_q;
    logic [OCW-1:0] o_cnt_q, o_cnt_d;
    logic           o_wr_req, o_wr_acc, o_rd_acc;

    // Status flags and FWFT head data, all derived from registered state
    always_comb begin
        npu_sfifo_empty     = (s_cnt_q == '0);
        npu_sfifo_full      = (s_cnt_q == SCW'(SFIFO_DEPTH));
        npu_ofifo_empty     = (o_cnt_q == '0);
        npu_ofifo_full      = (o_cnt_q == OCW'(OFIFO_DEPTH));
        npu_sfifo_dout      = npu_sfifo_empty ? 16'h0000 : s_mem[s_rd_ptr_q];
        npu_ofifo_dout      = npu_ofifo_empty ? 16'h0000 : o_mem[o_rd_ptr_q];
        npu_ofifo_count     = o_cnt_q;
        npu_router_overflow = overflow_q;
    end

    // Write/read acceptance; a full FIFO still accepts a write when it is read
    always_comb begin
        s_wr_req   = p1_valid_q & ~p1_dest_q;
        o_wr_req   = p1_valid_q & p1_dest_q;
        s_rd_acc   = npu_sfifo_rd_en & ~npu_sfifo_empty;
        o_rd_acc   = npu_ofifo_rd_en & ~npu_ofifo_empty;
        s_wr_acc   = s_wr_req & (~npu_sfifo_full | npu_sfifo_rd_en);
        o_wr_acc   = o_wr_req & (~npu_ofifo_full | npu_ofifo_rd_en);
        s_cnt_d    = s_cnt_q + SCW'(s_wr_acc) - SCW'(s_rd_acc);
        o_cnt_d    = o_cnt_q + OCW'(o_wr_acc) - OCW'(o_rd_acc);
        overflow_d = overflow_q
                   | (s_wr_req & npu_sfifo_full & ~npu_sfifo_rd_en)
                   | (o_wr_req & npu_ofifo_full & ~npu_ofifo_rd_en);
    end

    // Alignment stage, pointers, counts and sticky overflow
    always_ff @(posedge CLK or negedge npu_rst_n) begin
        if (!npu_rst_n) begin
            p1_valid_q <= 1'b0;
            p1_dest_q  <= 1'b0;
            overflow_q <= 1'b0;
            s_wr_ptr_q <= '0;
            s_rd_ptr_q <= '0;
            s_cnt_q    <= '0;
            o_wr_ptr_q <= '0;
            o_rd_ptr_q <= '0;
            o_cnt_q    <= '0;
        end else begin
            p1_valid_q <= npu_sched_sigmoid_valid;
            p1_dest_q  <= npu_sched_sigmoid_dest;
            overflow_q <= overflow_d;
            s_cnt_q    <= s_cnt_d;
            o_cnt_q    <= o_cnt_d;
            if (s_wr_acc) s_wr_ptr_q <= s_wr_ptr_q + SAW'(1);
            if (s_rd_acc) s_rd_ptr_q <= s_rd_ptr_q + SAW'(1);
            if (o_wr_acc) o_wr_ptr_q <= o_wr_ptr_q + OAW'(1);
            if (o_rd_acc) o_rd_ptr_q <= o_rd_ptr_q + OAW'(1);
        end
    end

    // Storage arrays; left unreset because head data is masked while empty
    always_ff @(posedge CLK) begin
        if (s_wr_acc) s_mem[s_wr_ptr_q] <= npu_sigmoid_dout;
        if (o_wr_acc) o_mem[o_wr_ptr_q] <= npu_sigmoid_dout;
    end

endmodule

// File: tb/tb_npu_sigmoid_router_fifo.sv
// Directed bench for npu_sigmoid_router_fifo with hand-computed expectations.
module tb_npu_sigmoid_router_fifo;

    logic        CLK = 1'b0;
    logic        npu_rst_n;
    logic        valid, dest;
    logic [15:0] sig_dout;
    logic        srd, ord;
    logic [15:0] sfifo_dout, ofifo_dout;
    logic        sfifo_empty, sfifo_full, ofifo_empty, ofifo_full;
    logic [4:0]  ofifo_count;
    logic        overflow;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] dout_pipe;
    logic [15:0] q [$];
    bit          pend;
    logic [15:0] pend_v;
    int          max_cnt;

    always #5 CLK = ~CLK;

    npu_sigmoid_router_fifo #(
        .SFIFO_DEPTH(8),
        .OFIFO_DEPTH(16)
    ) dut (
        .CLK                     (CLK),
        .npu_rst_n               (npu_rst_n),
        .npu_sched_sigmoid_valid (valid),
        .npu_sched_sigmoid_dest  (dest),
        .npu_sigmoid_dout        (sig_dout),
        .npu_sfifo_rd_en         (srd),
        .npu_ofifo_rd_en         (ord),
        .npu_sfifo_dout          (sfifo_dout),
        .npu_ofifo_dout          (ofifo_dout),
        .npu_sfifo_empty         (sfifo_empty),
        .npu_sfifo_full          (sfifo_full),
        .npu_ofifo_empty         (ofifo_empty),
        .npu_ofifo_full          (ofifo_full),
        .npu_ofifo_count         (ofifo_count),
        .npu_router_overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: the data argument belongs to this cycle's valid and is
    // presented to the DUT one cycle later, like the real sigmoid unit.
    task automatic cyc(input logic v, input logic d, input logic [15:0] data,
                       input logic rs, input logic ro);
        sig_dout  = dout_pipe;
        dout_pipe = data;
        valid     = v;
        dest      = d;
        srd       = rs;
        ord       = ro;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0; dest = 1'b0; srd = 1'b0; ord = 1'b0; sig_dout = 16'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        dout_pipe = 16'h0;
        npu_rst_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_s_empty", 32'(sfifo_empty), 32'd1);
        check("rst_s_full",  32'(sfifo_full),  32'd0);
        check("rst_s_dout",  32'(sfifo_dout),  32'h0);
        check("rst_o_empty", 32'(ofifo_empty), 32'd1);
        check("rst_o_full",  32'(ofifo_full),  32'd0);
        check("rst_o_count", 32'(ofifo_count), 32'd0);
        check("rst_o_dout",  32'(ofifo_dout),  32'h0);
        check("rst_ovf",     32'(overflow),    32'd0);
        npu_rst_n = 1'b1;
        cyc(0, 0, 16'h0, 0, 0);

        // Latency: result appears after the edge that follows valid
        cyc(1, 1, 16'h0080, 0, 0);
        check("lat_not_yet", 32'(ofifo_empty), 32'd1);
        cyc(0, 0, 16'h0, 0, 0);
        check("lat_empty", 32'(ofifo_empty), 32'd0);
        check("lat_dout",  32'(ofifo_dout),  32'h0080);
        check("lat_count", 32'(ofifo_count), 32'd1);
        cyc(0, 0, 16'h0, 0, 1);
        check("lat_pop_empty", 32'(ofifo_empty), 32'd1);
        check("lat_pop_dout",  32'(ofifo_dout),  32'h0);

        // Alternating routing, back-to-back
        for (int i = 1; i <= 6; i++) cyc(1, (i % 2 == 0), 16'(i), 0, 0);
        cyc(0, 0, 16'h0, 0, 0);
        check("rt_o_count", 32'(ofifo_count), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check("rt_s_dout", 32'(sfifo_dout), 32'(2 * k + 1));
            check("rt_o_dout", 32'(ofifo_dout), 32'(2 * k + 2));
            cyc(0, 0, 16'h0, 1, 1);
        end
        check("rt_s_empty", 32'(sfifo_empty), 32'd1);
        check("rt_o_empty", 32'(ofifo_empty), 32'd1);
        check("rt_ovf",     32'(overflow),    32'd0);

        // Overflow on the sigmoid FIFO
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 16'(16'h0010 + i), 0, 0);
            if (i == 7) check("ovf_full7", 32'(sfifo_full), 32'd0);
            if (i == 8) begin
                check("ovf_full8", 32'(sfifo_full), 32'd1);
                check("ovf_pre",   32'(overflow),   32'd0);
            end
        end
        cyc(0, 0, 16'h0, 0, 0);
        check("ovf_set",  32'(overflow),   32'd1);
        check("ovf_full", 32'(sfifo_full), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check("ovf_pop", 32'(sfifo_dout), 32'(16'h0010 + k));
            cyc(0, 0, 16'h0, 1, 0);
        end
        check("ovf_drained", 32'(sfifo_empty), 32'd1);
        check("ovf_sticky",  32'(overflow),    32'd1);
        cyc(0, 0, 16'h0, 1, 0);
        check("rd_empty_ign", 32'(sfifo_empty), 32'd1);
        check("rd_empty_dout", 32'(sfifo_dout), 32'h0);
        npu_rst_n = 1'b0;
        #1;
        check("ovf_async_clr", 32'(overflow), 32'd0);
        @(posedge CLK);
        #1;
        npu_rst_n = 1'b1;
        cyc(0, 0, 16'h0, 0, 0);

        // Full output FIFO: write plus read in the same cycle
        for (int i = 0; i < 16; i++) cyc(1, 1, 16'(16'h0100 + i), 0, 0);
        cyc(0, 0, 16'h0, 0, 0);
        check("sim_full",  32'(ofifo_full),  32'd1);
        check("sim_cnt16", 32'(ofifo_count), 32'd16);
        cyc(1, 1, 16'hFF80, 0, 0);
        check("sim_head", 32'(ofifo_dout), 32'h0100);
        cyc(0, 0, 16'h0, 0, 1);
        check("sim_cnt_keep",  32'(ofifo_count), 32'd16);
        check("sim_full_keep", 32'(ofifo_full),  32'd1);
        check("sim_no_ovf",    32'(overflow),    32'd0);
        for (int k = 1; k < 16; k++) begin
            check("sim_drain", 32'(ofifo_dout), 32'(16'h0100 + k));
            cyc(0, 0, 16'h0, 0, 1);
        end
        check("sim_last", 32'(ofifo_dout), 32'hFF80);
        cyc(0, 0, 16'h0, 0, 1);
        check("sim_empty", 32'(ofifo_empty), 32'd1);
        // Empty output FIFO: write plus read in the same cycle
        cyc(1, 1, 16'h0042, 0, 0);
        cyc(0, 0, 16'h0, 0, 1);
        check("emp_cnt1", 32'(ofifo_count), 32'd1);
        check("emp_dout", 32'(ofifo_dout),  32'h0042);
        cyc(0, 0, 16'h0, 0, 1);
        check("emp_drain", 32'(ofifo_empty), 32'd1);

        // Wrap-around: 40 interleaved pushes and pops
        pend    = 1'b0;
        pend_v  = 16'h0;
        max_cnt = 0;
        for (int i = 0; i < 41; i++) begin
            bit r;
            r = (q.size() > 0) && (i % 3 != 0);
            if (r) check("wrap_dout", 32'(ofifo_dout), 32'(q[0]));
            cyc(i < 40, 1, 16'(16'h2000 + i), 0, r);
            if (r) void'(q.pop_front());
            if (pend) q.push_back(pend_v);
            pend   = (i < 40);
            pend_v = 16'(16'h2000 + i);
            check("wrap_count", 32'(ofifo_count), 32'(q.size()));
            if (int'(ofifo_count) > max_cnt) max_cnt = int'(ofifo_count);
        end
        while (q.size() > 0) begin
            check("wrap_tail", 32'(ofifo_dout), 32'(q[0]));
            cyc(0, 0, 16'h0, 0, 1);
            void'(q.pop_front());
        end
        check("wrap_empty", 32'(ofifo_empty), 32'd1);
        check("wrap_max_le16", 32'(max_cnt <= 16), 32'd1);
        check("wrap_ovf", 32'(overflow), 32'd0);

        // Reset mid-stream with 5 stored and one result in flight
        for (int i = 0; i < 5; i++) cyc(1, 1, 16'(16'h0300 + i), 0, 0);
        cyc(1, 1, 16'h5555, 0, 0);
        check("mid_cnt5", 32'(ofifo_count), 32'd5);
        npu_rst_n = 1'b0;
        #1;
        check("mid_empty", 32'(ofifo_empty), 32'd1);
        check("mid_dout",  32'(ofifo_dout),  32'h0);
        check("mid_count", 32'(ofifo_count), 32'd0);
        check("mid_ovf",   32'(overflow),    32'd0);
        idle();
        dout_pipe = 16'h0;
        repeat (2) @(posedge CLK);
        #1;
        npu_rst_n = 1'b1;
        cyc(0, 0, 16'h0, 0, 0);
        cyc(0, 0, 16'h0, 0, 0);
        check("mid_rel_empty", 32'(ofifo_empty), 32'd1);
        check("mid_rel_count", 32'(ofifo_count), 32'd0);
        check("mid_rel_s_emp", 32'(sfifo_empty), 32'd1);
        cyc(1, 0, 16'hBEEF, 0, 0);
        cyc(0, 0, 16'h0, 0, 0);
        check("resume_dout",  32'(sfifo_dout),  32'hBEEF);
        check("resume_empty", 32'(sfifo_empty), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
